clock_set_ctrl: RTL and testbench
=================================

Name: clock_set_ctrl

Overview:
Mode/adjust sequencer for the century-clock counter chain. In RUN it passes the 1 Hz tick to the chain's count enable. In SET states it holds the chain (en low) and steers single-cycle up/down pulses to one selected field counter, with hold-to-repeat. It returns to RUN on a mode wrap or after an inactivity timeout. Sits between the debounced button front end and the counter instances.

Parameters:
NUM_FIELDS, 6, number of adjustable counters (0=sec,1=min,2=hour,3=day,4=month,5=year)
HOLD_CYCLES, 50000000, clk cycles a button must stay high before auto-repeat starts
REPEAT_CYCLES, 10000000, clk cycles between auto-repeat pulses
TIMEOUT_TICKS, 30, tick_i pulses with no button activity before forced return to RUN
CNT_W, 26, width of hold/repeat counter; must hold max(HOLD_CYCLES, REPEAT_CYCLES)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
tick_i  in  1  1-cycle 1 Hz strobe
btn_mode_i  in  1  mode button, synchronized and debounced level
btn_up_i  in  1  up button, synchronized and debounced level
btn_down_i  in  1  down button, synchronized and debounced level
run_en_o  in/out: out  1  count enable to seconds counter (tick_i gated by RUN)
up_o  out  NUM_FIELDS  one-hot up pulse to selected field counter
down_o  out  NUM_FIELDS  one-hot down pulse to selected field counter
set_mode_o  out  1  high in any SET state
field_sel_o  out  3  index of field being edited; 0 in RUN
blink_o  out  1  display blink phase; toggles on tick_i in SET, 0 in RUN

Behaviour:
- Reset (async, rst_n low): state RUN, all outputs 0, edge registers 0, hold/repeat counter 0, timeout counter 0.
- All outputs registered. Button edge = level high now and low in the previous cycle (internal prev-registers).
- run_en_o = tick_i registered in RUN: 1-cycle latency, 1 cycle wide. It is 0 in every SET state.
- FSM: RUN -> SET_0 on mode edge; SET_k -> SET_k+1 on mode edge; SET_(NUM_FIELDS-1) -> RUN on mode edge; any SET -> RUN on timeout.
- SET state entry forces blink_o=0, clears the timeout counter, and clears the hold counter.
- Up/down, SET only. The action needs exactly one of up/down high. Both high means no pulse and the hold counter is cleared.
  - Edge: the selected bit of up_o/down_o is high for exactly 1 cycle, the cycle after the edge is sampled. The hold counter is then cleared.
  - Held: after HOLD_CYCLES cycles high with no edge, 1 pulse; then 1 pulse every REPEAT_CYCLES while held. Release clears the counter.
  - up_o/down_o are never both nonzero. They are never nonzero in RUN. Buttons in RUN are ignored except for mode.
- Mode edge in the same cycle as an up/down edge: the mode transition wins and no pulse is issued. The hold counter is cleared, so a held button restarts the HOLD_CYCLES wait in the new field.
- Timeout: count tick_i in SET. Any up/down/mode edge or repeat pulse clears the count. Reaching TIMEOUT_TICKS returns to RUN in the next cycle. A button edge in the same cycle as the final tick cancels the timeout.
- blink_o toggles on each tick_i in SET.
- field_sel_o = k in SET_k.
- Pulse width of 1 cycle matches the counter contract: the counter acts on up/down only when en=0, once per cycle.

Test Plan:
- Reset mid-SET_2 while up held: run_en_o=0, up_o=0, field_sel_o=0, set_mode_o=0 immediately; after release, the FSM is in RUN.
- RUN, 5 tick_i strobes: run_en_o shows 5 single-cycle pulses, each 1 cycle after its tick; up_o/down_o stay 0.
- 7 mode edges from RUN: field_sel_o steps 0,1,2,3,4,5 with set_mode_o=1, then returns to RUN (set_mode_o=0).
- SET_1, up held 1 cycle: up_o=6'b000010 for exactly 1 cycle. SET_1, down held (bench HOLD_CYCLES=8, REPEAT_CYCLES=4) for 20 cycles: down_o pulses at the edge+1, then at +8, +12, +16, +20 relative to the edge.
- SET_3, up and down high together for 10 cycles: no pulses. Mode edge coincident with an up edge: field_sel_o advances to 4 and up_o stays 0.
- SET_0, no buttons, TIMEOUT_TICKS=3: return to RUN one cycle after the 3rd tick. Repeat with an up edge on tick 3: the FSM stays in SET_0 and the count restarts.

Source files
------------

// File: rtl/clock_set_ctrl.sv
// -----------------------------------------------------------------------------
// clock_set_ctrl
//
// Mode/adjust sequencer for the century-clock counter chain.
//   RUN   : the 1 Hz tick is forwarded (registered) to the chain count enable.
//   SET_k : the chain is held and single-cycle up/down pulses are steered to
//           field counter k, with hold-to-repeat. A mode press advances to the
//           next field (wrapping back to RUN after the last one). An inactivity
//           timeout, counted in ticks, also forces RUN.
//
// Ports
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   tick_i       1-cycle 1 Hz strobe
//   btn_mode_i   mode button level (synchronized, debounced)
//   btn_up_i     up button level (synchronized, debounced)
//   btn_down_i   down button level (synchronized, debounced)
//   run_en_o     count enable to the seconds counter (tick_i delayed 1 cycle, RUN only)
//   up_o         one-hot up pulse to the selected field counter
//   down_o       one-hot down pulse to the selected field counter
//   set_mode_o   high in any SET state
//   field_sel_o  index of the field being edited, 0 in RUN
//   blink_o      display blink phase, toggles on tick_i in SET, 0 in RUN
// -----------------------------------------------------------------------------
module clock_set_ctrl #(
   parameter int NUM_FIELDS    = 6,
   parameter int HOLD_CYCLES   = 50000000,
   parameter int REPEAT_CYCLES = 10000000,
   parameter int TIMEOUT_TICKS = 30,
   parameter int CNT_W         = 26
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  tick_i,
   input  logic                  btn_mode_i,
   input  logic                  btn_up_i,
   input  logic                  btn_down_i,
   output logic                  run_en_o,
   output logic [NUM_FIELDS-1:0] up_o,
   output logic [NUM_FIELDS-1:0] down_o,
   output logic                  set_mode_o,
   output logic [2:0]            field_sel_o,
   output logic                  blink_o
);

   localparam int TOUT_W = $clog2(TIMEOUT_TICKS + 1);

   // The edge cycle itself is already one held cycle, so the first auto pulse
   // fires after HOLD_CYCLES-1 further cycles; repeats are spaced by a full
   // REPEAT_CYCLES from the previous pulse.
   localparam logic [CNT_W-1:0]  HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0]  REPEAT_LAST = CNT_W'(REPEAT_CYCLES);
   localparam logic [TOUT_W-1:0] TOUT_LAST   = TOUT_W'(TIMEOUT_TICKS - 1);
   localparam logic [2:0]        FIELD_LAST  = 3'(NUM_FIELDS - 1);

   // The SET_k states share all behaviour except k, so the FSM is a RUN/SET
   // mode plus a field index rather than NUM_FIELDS+1 distinct enum values.
   typedef enum logic {
      MODE_RUN = 1'b0,
      MODE_SET = 1'b1
   } mode_e;

   mode_e                 mode_q, mode_d;
   logic [2:0]            field_q, field_d;
   logic                  mode_prev_q, up_prev_q, down_prev_q;
   logic [CNT_W-1:0]      hold_cnt_q, hold_cnt_d;
   logic                  repeat_q, repeat_d;
   logic [TOUT_W-1:0]     tout_q, tout_d;
   logic                  blink_q, blink_d;
   logic                  run_en_q, run_en_d;
   logic [NUM_FIELDS-1:0] up_q, up_d;
   logic [NUM_FIELDS-1:0] down_q, down_d;

   logic                  mode_edge, up_edge, down_edge;
   logic                  only_up, only_down;
   logic [CNT_W-1:0]      hold_inc;
   logic [NUM_FIELDS-1:0] sel_onehot;
   logic                  fire, rep_fire;

   assign mode_edge  = btn_mode_i & ~mode_prev_q;
   assign up_edge    = btn_up_i   & ~up_prev_q;
   assign down_edge  = btn_down_i & ~down_prev_q;
   assign only_up    = btn_up_i   & ~btn_down_i;
   assign only_down  = btn_down_i & ~btn_up_i;
   assign hold_inc   = hold_cnt_q + CNT_W'(1);
   assign sel_onehot = NUM_FIELDS'(1) << field_q;

   // NOTE: every signal written here gets a default first, so no path leaves
   // a value unassigned and no latch is inferred.
   always_comb begin
      mode_d     = mode_q;
      field_d    = field_q;
      hold_cnt_d = hold_cnt_q;
      repeat_d   = repeat_q;
      tout_d     = tout_q;
      blink_d    = blink_q;
      run_en_d   = 1'b0;
      up_d       = '0;
      down_d     = '0;
      fire       = 1'b0;
      rep_fire   = 1'b0;

      case (mode_q)
         MODE_RUN: begin
            // Up/down are ignored in RUN; only mode matters.
            hold_cnt_d = '0;
            repeat_d   = 1'b0;
            tout_d     = '0;
            blink_d    = 1'b0;
            field_d    = '0;
            run_en_d   = tick_i;
            if (mode_edge) begin
               mode_d   = MODE_SET;
               run_en_d = 1'b0;
            end
         end

         MODE_SET: begin
            if (mode_edge) begin
               // Mode wins over a coincident up/down edge; a still-held button
               // restarts its full hold wait in the new field.
               hold_cnt_d = '0;
               repeat_d   = 1'b0;
               tout_d     = '0;
               blink_d    = 1'b0;
               if (field_q == FIELD_LAST) begin
                  mode_d  = MODE_RUN;
                  field_d = '0;
               end else begin
                  field_d = field_q + 3'd1;
               end
            end else begin
               if (only_up || only_down) begin
                  if ((only_up && up_edge) || (only_down && down_edge)) begin
                     fire       = 1'b1;
                     hold_cnt_d = '0;
                     repeat_d   = 1'b0;
                  end else if (hold_inc == (repeat_q ? REPEAT_LAST : HOLD_LAST)) begin
                     fire       = 1'b1;
                     rep_fire   = 1'b1;
                     hold_cnt_d = '0;
                     repeat_d   = 1'b1;
                  end else begin
                     hold_cnt_d = hold_inc;
                  end
               end else begin
                  // Released, or both pressed: no action and the hold restarts.
                  hold_cnt_d = '0;
                  repeat_d   = 1'b0;
               end

               if (fire) begin
                  if (only_up) up_d   = sel_onehot;
                  else         down_d = sel_onehot;
               end

               // Activity in the same cycle as the final tick cancels the timeout.
               if (up_edge || down_edge || rep_fire) begin
                  tout_d = '0;
               end else if (tick_i) begin
                  if (tout_q == TOUT_LAST) begin
                     mode_d     = MODE_RUN;
                     field_d    = '0;
                     tout_d     = '0;
                     hold_cnt_d = '0;
                     repeat_d   = 1'b0;
                  end else begin
                     tout_d = tout_q + TOUT_W'(1);
                  end
               end

               if (mode_d == MODE_RUN)  blink_d = 1'b0;
               else if (tick_i)         blink_d = ~blink_q;
            end
         end
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples
   // the pre-edge values regardless of statement order.
   // NOTE: this block holds only control flops (no storage array), so every
   // one of them is reset to a known value.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mode_q      <= MODE_RUN;
         field_q     <= '0;
         mode_prev_q <= 1'b0;
         up_prev_q   <= 1'b0;
         down_prev_q <= 1'b0;
         hold_cnt_q  <= '0;
         repeat_q    <= 1'b0;
         tout_q      <= '0;
         blink_q     <= 1'b0;
         run_en_q    <= 1'b0;
         up_q        <= '0;
         down_q      <= '0;
      end else begin
         mode_q      <= mode_d;
         field_q     <= field_d;
         mode_prev_q <= btn_mode_i;
         up_prev_q   <= btn_up_i;
         down_prev_q <= btn_down_i;
         hold_cnt_q  <= hold_cnt_d;
         repeat_q    <= repeat_d;
         tout_q      <= tout_d;
         blink_q     <= blink_d;
         run_en_q    <= run_en_d;
         up_q        <= up_d;
         down_q      <= down_d;
      end
   end

   assign run_en_o    = run_en_q;
   assign up_o        = up_q;
   assign down_o      = down_q;
   assign set_mode_o  = (mode_q == MODE_SET);
   assign field_sel_o = field_q;
   assign blink_o     = blink_q;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// -----------------------------------------------------------------------------
// tb_clock_set_ctrl
//
// Directed bench for clock_set_ctrl with short hold/repeat/timeout parameters.
// Inputs change 1 time unit after a rising edge; outputs are read at that same
// point, so after step() they reflect the inputs held during the previous cycle.
// -----------------------------------------------------------------------------
module tb_clock_set_ctrl;

   localparam int NF = 6;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          tick_i = 1'b0;
   logic          btn_mode_i = 1'b0;
   logic          btn_up_i = 1'b0;
   logic          btn_down_i = 1'b0;
   logic          run_en_o;
   logic [NF-1:0] up_o;
   logic [NF-1:0] down_o;
   logic          set_mode_o;
   logic [2:0]    field_sel_o;
   logic          blink_o;

   int n_checks = 0;
   int n_pass   = 0;

   clock_set_ctrl #(
      .NUM_FIELDS   (NF),
      .HOLD_CYCLES  (8),
      .REPEAT_CYCLES(4),
      .TIMEOUT_TICKS(3),
      .CNT_W        (8)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .tick_i     (tick_i),
      .btn_mode_i (btn_mode_i),
      .btn_up_i   (btn_up_i),
      .btn_down_i (btn_down_i),
      .run_en_o   (run_en_o),
      .up_o       (up_o),
      .down_o     (down_o),
      .set_mode_o (set_mode_o),
      .field_sel_o(field_sel_o),
      .blink_o    (blink_o)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic press_mode();
      btn_mode_i = 1'b1;
      step();
      btn_mode_i = 1'b0;
      step();
   endtask

   task automatic tick_once();
      tick_i = 1'b1;
      step();
      tick_i = 1'b0;
      step();
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, ".run_en"}, 32'(run_en_o), 32'd0);
      check({tag, ".up"},     32'(up_o),     32'd0);
      check({tag, ".down"},   32'(down_o),   32'd0);
      check({tag, ".set"},    32'(set_mode_o), 32'd0);
      check({tag, ".field"},  32'(field_sel_o), 32'd0);
      check({tag, ".blink"},  32'(blink_o),  32'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // ---- reset state ----
      #1;
      check_all_zero("reset");
      step();
      rst_n = 1'b1;
      step();
      check_all_zero("post_reset");

      // ---- RUN: 5 ticks -> 5 single-cycle enables, 1 cycle late ----
      for (int i = 0; i < 5; i++) begin
         tick_i = 1'b1;
         step();
         check($sformatf("run_tick%0d.en", i), 32'(run_en_o), 32'd1);
         check($sformatf("run_tick%0d.up", i), 32'(up_o | down_o), 32'd0);
         tick_i = 1'b0;
         step();
         check($sformatf("run_tick%0d.en_low", i), 32'(run_en_o), 32'd0);
         step();
      end

      // ---- 7 mode edges: SET_0..SET_5 then RUN ----
      for (int i = 0; i < 7; i++) begin
         btn_mode_i = 1'b1;
         step();
         check($sformatf("mode%0d.set", i),   32'(set_mode_o),  (i < 6) ? 32'd1 : 32'd0);
         check($sformatf("mode%0d.field", i), 32'(field_sel_o), (i < 6) ? 32'(i) : 32'd0);
         btn_mode_i = 1'b0;
         step();
      end

      // ---- SET_1: short up press -> one pulse on bit 1 ----
      press_mode();
      press_mode();
      check("set1.field", 32'(field_sel_o), 32'd1);
      btn_up_i = 1'b1;
      step();
      check("set1.up_pulse", 32'(up_o), 32'h02);
      check("set1.down_idle", 32'(down_o), 32'd0);
      btn_up_i = 1'b0;
      step();
      check("set1.up_done", 32'(up_o), 32'd0);
      step();

      // ---- SET_1: down held 20 cycles, pulses at +1, +8, +12, +16, +20 ----
      btn_down_i = 1'b1;
      for (int k = 1; k <= 20; k++) begin
         step();
         check($sformatf("hold.k%0d", k), 32'(down_o),
               (k == 1 || k == 8 || k == 12 || k == 16 || k == 20) ? 32'h02 : 32'd0);
         check($sformatf("hold.k%0d.up", k), 32'(up_o), 32'd0);
      end
      btn_down_i = 1'b0;
      step();
      check("hold.release", 32'(down_o), 32'd0);
      step();

      // ---- SET_3: both buttons together -> nothing ----
      press_mode();
      press_mode();
      check("set3.field", 32'(field_sel_o), 32'd3);
      btn_up_i   = 1'b1;
      btn_down_i = 1'b1;
      for (int k = 0; k < 10; k++) begin
         step();
         check($sformatf("both.k%0d", k), 32'(up_o | down_o), 32'd0);
      end
      btn_up_i   = 1'b0;
      btn_down_i = 1'b0;
      step();
      step();

      // ---- mode edge coincident with up edge: mode wins ----
      btn_mode_i = 1'b1;
      btn_up_i   = 1'b1;
      step();
      check("coinc.field", 32'(field_sel_o), 32'd4);
      check("coinc.up",    32'(up_o), 32'd0);
      btn_mode_i = 1'b0;
      for (int k = 0; k < 3; k++) begin
         step();
         check($sformatf("coinc.held%0d", k), 32'(up_o), 32'd0);
      end
      btn_up_i = 1'b0;
      step();

      // ---- timeout in SET_0 after 3 ticks ----
      press_mode();                         // SET_5
      press_mode();                         // RUN
      check("to.run", 32'(set_mode_o), 32'd0);
      press_mode();                         // SET_0
      check("to.set0", 32'(set_mode_o), 32'd1);
      check("to.field0", 32'(field_sel_o), 32'd0);
      tick_i = 1'b1;
      step();
      check("to.blink1", 32'(blink_o), 32'd1);
      tick_i = 1'b0;
      step();
      tick_once();
      check("to.after2.set", 32'(set_mode_o), 32'd1);
      check("to.after2.blink", 32'(blink_o), 32'd0);
      tick_i = 1'b1;
      step();
      check("to.after3.set",   32'(set_mode_o), 32'd0);
      check("to.after3.run_en", 32'(run_en_o), 32'd0);
      check("to.after3.blink", 32'(blink_o), 32'd0);
      tick_i = 1'b0;
      step();

      // ---- timeout cancelled by up edge on the final tick ----
      press_mode();                         // SET_0
      check("cancel.set0", 32'(set_mode_o), 32'd1);
      tick_once();
      tick_once();
      tick_i   = 1'b1;
      btn_up_i = 1'b1;
      step();
      check("cancel.set",   32'(set_mode_o), 32'd1);
      check("cancel.pulse", 32'(up_o), 32'h01);
      tick_i   = 1'b0;
      btn_up_i = 1'b0;
      step();
      tick_once();
      tick_once();
      check("cancel.restart2", 32'(set_mode_o), 32'd1);
      tick_i = 1'b1;
      step();
      check("cancel.restart3", 32'(set_mode_o), 32'd0);
      tick_i = 1'b0;
      step();

      // ---- reset mid-SET_2 with up held ----
      press_mode();
      press_mode();
      press_mode();
      check("rst.field2", 32'(field_sel_o), 32'd2);
      btn_up_i = 1'b1;
      step();
      check("rst.pulse", 32'(up_o), 32'h04);
      step();
      #2;
      rst_n = 1'b0;
      #1;
      check_all_zero("rst.async");
      step();
      rst_n = 1'b1;
      step();
      btn_up_i = 1'b0;
      step();
      check("rst.after.set",   32'(set_mode_o), 32'd0);
      check("rst.after.field", 32'(field_sel_o), 32'd0);
      tick_i = 1'b1;
      step();
      check("rst.after.run_en", 32'(run_en_o), 32'd1);
      tick_i = 1'b0;
      step();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
